counter_seq_ctrl: RTL and testbench

Command-driven sequencer for the 4-bit hex counter datapath.
- Accepts a count job over a valid/ready handshake: start value, end value, direction, prescale divider, reload flag.
- Steps the counter from start to end, with wrap-around, at a programmable tick rate.
- Signals completion, supports auto-reload, pause (hold) and abort.
- Sits between the control plane and the display/timing logic that consumes q.

---
 rtl/counter_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Command-driven sequencer for a WIDTH-bit wrap-around counter. A job
//   (start, end, direction, prescale divider, reload) is taken over a
//   valid/ready handshake. The counter then steps from start to end, one
//   step every div+1 unheld cycles. It pulses done when it reaches end, and
//   either restarts (reload) or returns to idle. hold freezes the job and
//   abort cancels it.
//
// Ports
//   clk        rising-edge clock
//   res        synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (IDLE and not in reset), combinational
//   cmd_start  first count value
//   cmd_end    terminal count value
//   cmd_dir    0 = count up, 1 = count down
//   cmd_div    tick every cmd_div+1 running cycles
//   cmd_reload 1 = restart from start after reaching end
//   hold       freeze prescaler and counter while running
//   abort      terminate the running job (no done pulse)
//   q          counter value
//   busy       job running
//   done       one-cycle pulse on job or lap completion
//   laps       completed laps of the current job, saturating
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 4,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             cmd_reload,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] laps
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [WIDTH-1:0]   end_q, end_d;
  logic               dir_q, dir_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               reload_q, reload_d;
  logic               done_q, done_d;
  logic [LAP_W-1:0]   laps_q, laps_d;

  assign cmd_ready = (state_q == IDLE) && !res;
  assign q         = count_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign laps      = laps_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pre_d    = pre_q;
    start_d  = start_q;
    end_d    = end_q;
    dir_d    = dir_q;
    div_d    = div_q;
    reload_d = reload_q;
    laps_d   = laps_q;
    done_d   = 1'b0;  // done is a pulse: cleared on every edge that does not set it

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          start_d  = cmd_start;
          end_d    = cmd_end;
          dir_d    = cmd_dir;
          div_d    = cmd_div;
          reload_d = cmd_reload;
          count_d  = cmd_start;
          pre_d    = '0;
          laps_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Priority: abort, then hold, then the prescaled tick.
        if (abort) begin
          state_d = IDLE;
        end else if (!hold) begin
          if (pre_q == div_q) begin
            pre_d = '0;
            if (count_q != end_q) begin
              count_d = dir_q ? count_q - 1'b1 : count_q + 1'b1;
            end else begin
              done_d = 1'b1;
              if (laps_q != '1) begin
                laps_d = laps_q + 1'b1;
              end
              if (reload_q) begin
                count_d = start_q;
              end else begin
                state_d = IDLE;  // q keeps showing the end value
              end
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      count_q  <= '0;
      pre_q    <= '0;
      start_q  <= '0;
      end_q    <= '0;
      dir_q    <= 1'b0;
      div_q    <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      laps_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      start_q  <= start_d;
      end_q    <= end_d;
      dir_q    <= dir_d;
      div_q    <= div_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      laps_q   <= laps_d;
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl: table-driven per-cycle vectors with a
// scoreboard queue of expected outputs, plus hand-written multi-cycle
// sequences (bounded wait for completion, lap-counter saturation).
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_start = '0;
  logic [3:0] cmd_end = '0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_div = '0;
  logic       cmd_reload = 1'b0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic [7:0] laps;

  counter_seq_ctrl #(.WIDTH(4), .DIV_W(4), .LAP_W(8)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_dir(cmd_dir),
    .cmd_div(cmd_div), .cmd_reload(cmd_reload), .hold(hold), .abort(abort),
    .q(q), .busy(busy), .done(done), .laps(laps)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       res, vld;
    logic [3:0] st, en;
    logic       dir;
    logic [3:0] div;
    logic       rl, hold, abort;
    logic [3:0] eq;
    logic       eb, ed;
    logic [7:0] el;
    logic       er;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] eq;
    logic       eb, ed;
    logic [7:0] el;
    logic       er;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input string name, input logic r, input logic vld,
                     input int st, input int en, input logic dir, input int div,
                     input logic rl, input logic hd, input logic ab,
                     input int eq, input logic eb, input logic ed, input int el,
                     input logic er);
    vec_t v;
    v.name = name; v.res = r; v.vld = vld; v.st = 4'(st); v.en = 4'(en);
    v.dir = dir; v.div = 4'(div); v.rl = rl; v.hold = hd; v.abort = ab;
    v.eq = 4'(eq); v.eb = eb; v.ed = ed; v.el = 8'(el); v.er = er;
    vecs.push_back(v);
  endtask

  // Plain running/idle row: no command, no hold, no abort.
  task automatic run(input string name, input int eq, input logic eb,
                     input logic ed, input int el, input logic er);
    add(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, eq, eb, ed, el, er);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic issue(input int st, input int en, input logic dir,
                       input int div, input logic rl);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 4'(st); cmd_end = 4'(en);
    cmd_dir = dir; cmd_div = 4'(div); cmd_reload = rl;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    // name            res vld st en dir div rl hold abort | q busy done laps ready
    add("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    run("idle0",                                      0, 0, 0, 0, 1);
    // 1: 3..6 up, div 0
    add("t1_acc",       0, 1, 3, 6, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
    run("t1_q4",   4, 1, 0, 0, 0);
    run("t1_q5",   5, 1, 0, 0, 0);
    run("t1_q6",   6, 1, 0, 0, 0);
    run("t1_done", 6, 0, 1, 1, 1);
    run("t1_idle", 6, 0, 0, 1, 1);
    // 2: 1..14 down, div 1, wraps through 0
    add("t2_acc",       0, 1, 1, 14, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    run("t2_a",  1, 1, 0, 0, 0);
    run("t2_b",  0, 1, 0, 0, 0);
    run("t2_c",  0, 1, 0, 0, 0);
    run("t2_d", 15, 1, 0, 0, 0);
    run("t2_e", 15, 1, 0, 0, 0);
    run("t2_f", 14, 1, 0, 0, 0);
    run("t2_g", 14, 1, 0, 0, 0);
    run("t2_done", 14, 0, 1, 1, 1);
    run("t2_idle", 14, 0, 0, 1, 1);
    // 3: 0..2 up, reload, then abort after lap 3
    add("t3_acc",       0, 1, 0, 2, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0);
    run("t3_q1", 1, 1, 0, 0, 0);
    run("t3_q2", 2, 1, 0, 0, 0);
    run("t3_lap1", 0, 1, 1, 1, 0);
    run("t3_q1b", 1, 1, 0, 1, 0);
    run("t3_q2b", 2, 1, 0, 1, 0);
    run("t3_lap2", 0, 1, 1, 2, 0);
    run("t3_q1c", 1, 1, 0, 2, 0);
    run("t3_q2c", 2, 1, 0, 2, 0);
    run("t3_lap3", 0, 1, 1, 3, 0);
    add("t3_abort",     0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 3, 1);
    add("t3_idle_ab",   0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 3, 1);
    // 4: 5..7 up, div 2, hold for 4 cycles mid-prescale, cmd_valid ignored
    add("t4_acc",       0, 1, 5, 7, 0, 2, 0, 0, 0,   5, 1, 0, 0, 0);
    run("t4_5a", 5, 1, 0, 0, 0);
    run("t4_5b", 5, 1, 0, 0, 0);
    run("t4_6a", 6, 1, 0, 0, 0);
    run("t4_6b", 6, 1, 0, 0, 0);
    add("t4_hold1",     0, 0, 0, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0, 0);
    add("t4_hold2",     0, 0, 0, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0, 0);
    add("t4_hold3",     0, 0, 0, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0, 0);
    add("t4_hold4",     0, 0, 0, 0, 0, 0, 0, 1, 0,   6, 1, 0, 0, 0);
    run("t4_6c", 6, 1, 0, 0, 0);
    run("t4_7a", 7, 1, 0, 0, 0);
    run("t4_7b", 7, 1, 0, 0, 0);
    add("t4_vld_ign",   0, 1, 0, 3, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0);
    run("t4_done", 7, 0, 1, 1, 1);
    // 5b: abort and hold in the same cycle, abort wins
    add("t5_acc",       0, 1, 2, 9, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add("t5_abhold",    0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 0, 0, 0, 1);
    // 6: reset mid-run with cmd_valid high, accepted only after res drops
    add("t6_acc",       0, 1, 4, 12, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0);
    run("t6_q5", 5, 1, 0, 0, 0);
    add("t6_res",       1, 1, 1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add("t6_acc2",      0, 1, 1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    run("t6_q2", 2, 1, 0, 0, 0);
    run("t6_done", 2, 0, 1, 1, 1);

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      res = vecs[i].res; cmd_valid = vecs[i].vld; cmd_start = vecs[i].st;
      cmd_end = vecs[i].en; cmd_dir = vecs[i].dir; cmd_div = vecs[i].div;
      cmd_reload = vecs[i].rl; hold = vecs[i].hold; abort = vecs[i].abort;
      e.name = vecs[i].name; e.eq = vecs[i].eq; e.eb = vecs[i].eb;
      e.ed = vecs[i].ed; e.el = vecs[i].el; e.er = vecs[i].er;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.name, ".q"}, int'(q), int'(e.eq));
      check({e.name, ".busy"}, int'(busy), int'(e.eb));
      check({e.name, ".done"}, int'(done), int'(e.ed));
      check({e.name, ".laps"}, int'(laps), int'(e.el));
      check({e.name, ".ready"}, int'(cmd_ready), int'(e.er));
      $display("vec %-12s q=%0d busy=%0d done=%0d laps=%0d ready=%0d",
               e.name, q, busy, done, laps, cmd_ready);
    end

    @(negedge clk);
    res = 1'b0; cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0;

    // 5: start == end, div 3 -> done on the 4th edge after accept
    begin
      int n;
      issue(9, 9, 0, 3, 0);
      n = 0;
      while (n < 20) begin
        @(posedge clk);
        #1;
        n++;
        if (done) break;
      end
      check("t5_done_latency", n, 4);
      check("t5_q", int'(q), 9);
      check("t5_busy", int'(busy), 0);
      $display("seq t5 done after %0d cycles q=%0d", n, q);
    end

    // Lap counter saturation: start==end with reload completes a lap each cycle
    begin
      issue(0, 0, 0, 0, 1);
      repeat (260) @(posedge clk);
      #1;
      check("sat_laps", int'(laps), 255);
      check("sat_busy", int'(busy), 1);
      check("sat_done", int'(done), 1);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("sat_abort_busy", int'(busy), 0);
      check("sat_abort_laps", int'(laps), 255);
      $display("seq sat laps=%0d busy=%0d", laps, busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
